// File: rtl/hex7seg_scan.sv
// Purpose: time-multiplexed hex 7-segment driver with per-frame input snapshot, LZ suppression, blanking.
// Latency: seg/an are registered, one clock behind the internal (cnt, idx, shadow) state; frame one clock after frame start.
// Backpressure: none; free-running scan, inputs may change any cycle and take effect at the next frame start.
module hex7seg_scan #(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz_en,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [7:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic                frame_start;

   logic [4*DIGITS-1:0] sh_value;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_blank;
   logic                sh_lz;

   logic [3:0]          nib;
   logic                sel_dp;
   logic                sel_blank;
   logic                upper_zero;
   logic                lz_hit;
   logic [6:0]          code;
   logic [DIGITS-1:0]   an_sel;
   logic [7:0]          seg_nxt;
   logic [DIGITS-1:0]   an_nxt;

   assign frame_start = (cnt == '0) && (idx == '0);

   // Slot counter and digit index: idx steps once per PRESCALE clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Snapshot the inputs once per frame so a digit set is never shown torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_value <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         sh_lz    <= 1'b0;
      end else if (frame_start) begin
         sh_value <= value;
         sh_dp    <= dp;
         sh_blank <= blank;
         sh_lz    <= lz_en;
      end
   end

   // Select the current digit and decide leading-zero suppression (all nibbles from idx upward are zero).
   always_comb begin
      nib        = 4'h0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      upper_zero = 1'b1;
      an_sel     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i == int'(idx)) begin
            nib       = sh_value[4*i +: 4];
            sel_dp    = sh_dp[i];
            sel_blank = sh_blank[i];
            an_sel[i] = 1'b1;
         end
         if ((i >= int'(idx)) && (sh_value[4*i +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
      end
      lz_hit = sh_lz && (idx != '0) && upper_zero;
   end

   // Hex to segment decode, positive logic, bit order g..a.
   always_comb begin
      code = 7'h00;
      case (nib)
         4'h0: code = 7'h3F;
         4'h1: code = 7'h06;
         4'h2: code = 7'h5B;
         4'h3: code = 7'h4F;
         4'h4: code = 7'h66;
         4'h5: code = 7'h6D;
         4'h6: code = 7'h7D;
         4'h7: code = 7'h07;
         4'h8: code = 7'h7F;
         4'h9: code = 7'h6F;
         4'hA: code = 7'h77;
         4'hB: code = 7'h7C;
         4'hC: code = 7'h39;
         4'hD: code = 7'h5E;
         4'hE: code = 7'h79;
         default: code = 7'h71;
      endcase
   end

   // Drive selection: dead clock at slot start and blanked digits stay fully dark.
   always_comb begin
      seg_nxt = 8'h00;
      an_nxt  = '0;
      if ((cnt != '0) && !sel_blank) begin
         seg_nxt = {sel_dp, lz_hit ? 7'h00 : code};
         an_nxt  = an_sel;
      end
   end

   // Output registers with polarity applied; reset parks the display dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg   <= SEG_INV;
         an    <= AN_INV;
         frame <= 1'b0;
      end else begin
         seg   <= seg_nxt ^ SEG_INV;
         an    <= an_nxt ^ AN_INV;
         frame <= frame_start;
      end
   end

endmodule
